// File: rtl/dickson_phase_gen_if.sv
// rtl/dickson_phase_gen_if.sv - config/feedback inputs and phase outputs of the pump clock generator
//
// Ports (signals carried by the interface):
//   en         run request
//   mode       0 = two-phase (phases 0,1), 1 = NUM_PHASES rotation
//   div        DRIVE length minus 1, in clk cycles
//   dead       DEAD length minus 1, in clk cycles
//   fb_above   asynchronous comparator output, 1 = pump output above target
//   phase_out  pump clock phases, at most one bit high
//   busy       high whenever the generator is not idle
//   regulating high while drive is withheld by feedback
// Modports: master drives config/feedback, slave is the generator.
interface dickson_phase_gen_if #(
   parameter int NUM_PHASES = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int DEAD_WIDTH = 4
);
   logic                  en;
   logic                  mode;
   logic [DIV_WIDTH-1:0]  div;
   logic [DEAD_WIDTH-1:0] dead;
   logic                  fb_above;
   logic [NUM_PHASES-1:0] phase_out;
   logic                  busy;
   logic                  regulating;

   modport master (
      output en, mode, div, dead, fb_above,
      input  phase_out, busy, regulating
   );

   modport slave (
      input  en, mode, div, dead, fb_above,
      output phase_out, busy, regulating
   );
endinterface

// File: rtl/dickson_phase_gen.sv
// rtl/dickson_phase_gen.sv - non-overlapping N-phase pump clock generator with pulse-skip regulation
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  dickson_phase_gen_if.slave: en, mode, div, dead, fb_above in;
//        phase_out, busy, regulating out (all outputs registered)
module dickson_phase_gen #(
   parameter int NUM_PHASES = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int DEAD_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   dickson_phase_gen_if.slave     bus
);
   localparam int IDX_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEAD,
      S_HOLD,
      S_DRIVE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [IDX_W-1:0]      w_idx_inc;
   logic [IDX_W-1:0]      w_last_idx;
   logic                  r_mode_q;
   logic                  w_mode_nxt;
   logic [DIV_WIDTH-1:0]  r_div_cnt;
   logic [DIV_WIDTH-1:0]  w_div_cnt_nxt;
   logic [DEAD_WIDTH-1:0] r_dead_cnt;
   logic [DEAD_WIDTH-1:0] w_dead_cnt_nxt;
   logic                  r_fb_meta;
   logic                  r_fb_s;
   logic [NUM_PHASES-1:0] r_phase_out;
   logic [NUM_PHASES-1:0] w_phase_nxt;
   logic [NUM_PHASES-1:0] w_phase_one;
   logic                  r_busy;
   logic                  r_regulating;

   assign bus.phase_out  = r_phase_out;
   assign bus.busy       = r_busy;
   assign bus.regulating = r_regulating;

   assign w_phase_one = {{(NUM_PHASES-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_mode_q     <= 1'b0;
         r_div_cnt    <= '0;
         r_dead_cnt   <= '0;
         r_fb_meta    <= 1'b0;
         r_fb_s       <= 1'b0;
         r_phase_out  <= '0;
         r_busy       <= 1'b0;
         r_regulating <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_mode_q     <= w_mode_nxt;
         r_div_cnt    <= w_div_cnt_nxt;
         r_dead_cnt   <= w_dead_cnt_nxt;
         r_fb_meta    <= bus.fb_above;
         r_fb_s       <= r_fb_meta;
         r_phase_out  <= w_phase_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_regulating <= (w_state_nxt == S_HOLD);
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_mode_nxt     = r_mode_q;
      w_div_cnt_nxt  = r_div_cnt;
      w_dead_cnt_nxt = r_dead_cnt;

      // Rotation wraps after phase 1 in two-phase mode, else after the last phase
      w_last_idx = r_mode_q ? IDX_W'(NUM_PHASES - 1) : IDX_W'(1);
      w_idx_inc  = (r_idx == w_last_idx) ? '0 : r_idx + IDX_W'(1);

      case (r_state)
         S_IDLE: begin
            w_idx_nxt = '0;
            if (bus.en) begin
               w_mode_nxt     = bus.mode;
               w_dead_cnt_nxt = bus.dead;
               w_state_nxt    = S_DEAD;
            end
         end
         S_DEAD: begin
            if (r_dead_cnt != '0) begin
               w_dead_cnt_nxt = r_dead_cnt - DEAD_WIDTH'(1);
            end else if (!bus.en) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (r_fb_s) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_div_cnt_nxt = bus.div;
               w_state_nxt   = S_DRIVE;
            end
         end
         S_HOLD: begin
            if (!bus.en) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (!r_fb_s) begin
               w_div_cnt_nxt = bus.div;
               w_state_nxt   = S_DRIVE;
            end
         end
         S_DRIVE: begin
            // Dropping en cuts the pulse short but still pays a full dead time
            if ((r_div_cnt == '0) || !bus.en) begin
               w_dead_cnt_nxt = bus.dead;
               w_idx_nxt      = w_idx_inc;
               w_state_nxt    = S_DEAD;
            end else begin
               w_div_cnt_nxt = r_div_cnt - DIV_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
      endcase

      // Outputs are registered from the next state so they line up with it
      w_phase_nxt = (w_state_nxt == S_DRIVE) ? (w_phase_one << w_idx_nxt) : '0;
   end
endmodule

// File: tb/tb_dickson_phase_gen.sv
// tb/tb_dickson_phase_gen.sv - self-checking bench for dickson_phase_gen
module tb_dickson_phase_gen;
   localparam int NP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   dickson_phase_gen_if #(.NUM_PHASES(NP), .DIV_WIDTH(8), .DEAD_WIDTH(4)) bus_if ();

   dickson_phase_gen #(.NUM_PHASES(NP), .DIV_WIDTH(8), .DEAD_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Segment model: kind 0 idle, 1 dead, 2 hold, 3 drive; elapsed counts up to len
   int   m_kind    = 0;
   int   m_elapsed = 0;
   int   m_len     = 1;
   int   m_idx     = 0;
   int   m_p       = 2;
   logic m_fb1     = 1'b0;
   logic m_fbs     = 1'b0;
   logic m_fb_now;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_kind = 0; m_elapsed = 0; m_len = 1; m_idx = 0; m_p = 2;
         m_fb1 = 1'b0; m_fbs = 1'b0;
      end else begin
         m_fb_now = m_fbs;
         m_fbs    = m_fb1;
         m_fb1    = bus_if.fb_above;
         case (m_kind)
            0: if (bus_if.en) begin
               m_p = bus_if.mode ? NP : 2;
               m_kind = 1; m_elapsed = 0; m_len = int'(bus_if.dead) + 1;
            end
            1: begin
               m_elapsed++;
               if (m_elapsed == m_len) begin
                  if (!bus_if.en) begin m_kind = 0; m_idx = 0; end
                  else if (m_fb_now) m_kind = 2;
                  else begin m_kind = 3; m_elapsed = 0; m_len = int'(bus_if.div) + 1; end
               end
            end
            2: begin
               if (!bus_if.en) begin m_kind = 0; m_idx = 0; end
               else if (!m_fb_now) begin m_kind = 3; m_elapsed = 0; m_len = int'(bus_if.div) + 1; end
            end
            default: begin
               m_elapsed++;
               if (m_elapsed == m_len || !bus_if.en) begin
                  m_idx = (m_idx + 1) % m_p;
                  m_kind = 1; m_elapsed = 0; m_len = int'(bus_if.dead) + 1;
               end
            end
         endcase
      end
   end

   logic [NP-1:0] exp_phase;
   always_comb exp_phase = (m_kind == 3) ? NP'(1 << m_idx) : '0;

   always @(negedge clk) begin
      if (!rst) begin
         n_vec++;
         if (bus_if.phase_out !== exp_phase) begin
            n_err++;
            $display("FAIL model_phase: got %b expected %b at %0t", bus_if.phase_out, exp_phase, $time);
         end
         n_vec++;
         if (bus_if.busy !== (m_kind != 0)) begin
            n_err++;
            $display("FAIL model_busy: got %b expected %b at %0t", bus_if.busy, (m_kind != 0), $time);
         end
         n_vec++;
         if (bus_if.regulating !== (m_kind == 2)) begin
            n_err++;
            $display("FAIL model_regulating: got %b expected %b at %0t", bus_if.regulating, (m_kind == 2), $time);
         end
         n_vec++;
         if (!$onehot0(bus_if.phase_out)) begin
            n_err++;
            $display("FAIL onehot: got %b expected at most one bit at %0t", bus_if.phase_out, $time);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_phase(input logic [NP-1:0] ph, input string name);
      for (int i = 0; i < 200 && bus_if.phase_out !== ph; i++) @(negedge clk);
      check(name, 32'(bus_if.phase_out), 32'(ph));
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && bus_if.busy !== 1'b0; i++) @(negedge clk);
      check(name, 32'(bus_if.busy), 32'd0);
   endtask

   task automatic wait_nonzero(input string name, input logic [NP-1:0] ph);
      for (int i = 0; i < 200 && bus_if.phase_out === '0; i++) @(negedge clk);
      check(name, 32'(bus_if.phase_out), 32'(ph));
   endtask

   function automatic logic [NP-1:0] two_phase_exp(input int k);
      int pos;
      pos = k % 12;
      if (pos < 2) return 4'b0000;
      else if (pos < 6) return 4'b0001;
      else if (pos < 8) return 4'b0000;
      else return 4'b0010;
   endfunction

   logic [NP-1:0] last_ph;
   logic [NP-1:0] prev_ph;
   logic [NP-1:0] cur_ph;
   bit            first_pulse;
   int            cnt;

   initial begin
      bus_if.en = 1'b0; bus_if.mode = 1'b0; bus_if.div = '0; bus_if.dead = '0;
      bus_if.fb_above = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_phase", 32'(bus_if.phase_out), 32'd0);
      check("reset_busy", 32'(bus_if.busy), 32'd0);
      check("reset_regulating", 32'(bus_if.regulating), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(bus_if.busy), 32'd0);

      // Two-phase, div=3 dead=1: 12-cycle period
      bus_if.mode = 1'b0; bus_if.div = 8'd3; bus_if.dead = 4'd1; bus_if.en = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         check("two_phase_seq", 32'(bus_if.phase_out), 32'(two_phase_exp(k)));
      end
      bus_if.en = 1'b0;
      wait_idle("two_phase_stop");

      // Four-phase minimum timing
      bus_if.mode = 1'b1; bus_if.div = 8'd0; bus_if.dead = 4'd0; bus_if.en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check("four_phase_seq", 32'(bus_if.phase_out),
               (k % 2 == 0) ? 32'd0 : (32'd1 << ((k / 2) % 4)));
      end
      bus_if.en = 1'b0;
      wait_idle("four_phase_stop");

      // Regulation
      bus_if.mode = 1'b1; bus_if.div = 8'd2; bus_if.dead = 4'd1; bus_if.en = 1'b1;
      wait_phase(4'b0010, "reg_reach_phase1");
      bus_if.fb_above = 1'b1;
      repeat (10) @(negedge clk);
      check("reg_hold_phase", 32'(bus_if.phase_out), 32'd0);
      check("reg_hold_flag", 32'(bus_if.regulating), 32'd1);
      check("reg_hold_busy", 32'(bus_if.busy), 32'd1);
      bus_if.fb_above = 1'b0;
      @(negedge clk);
      check("reg_release_e1", 32'(bus_if.regulating), 32'd1);
      @(negedge clk);
      check("reg_release_e2", 32'(bus_if.regulating), 32'd1);
      @(negedge clk);
      check("reg_release_phase", 32'(bus_if.phase_out), 32'h4);
      check("reg_release_flag", 32'(bus_if.regulating), 32'd0);

      // Stop during second cycle of phase 2, then restart in two-phase mode
      bus_if.div = 8'd5; bus_if.dead = 4'd2;
      for (int i = 0; i < 50 && bus_if.phase_out === 4'b0100; i++) @(negedge clk);
      wait_phase(4'b0100, "stop_reach_phase2");
      @(negedge clk);
      check("stop_second_cycle", 32'(bus_if.phase_out), 32'h4);
      bus_if.en = 1'b0;
      @(negedge clk);
      check("stop_phase_off", 32'(bus_if.phase_out), 32'd0);
      check("stop_dead1_busy", 32'(bus_if.busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("stop_dead3_busy", 32'(bus_if.busy), 32'd1);
      @(negedge clk);
      check("stop_idle", 32'(bus_if.busy), 32'd0);
      bus_if.mode = 1'b0; bus_if.en = 1'b1;
      first_pulse = 1'b1; last_ph = '0; prev_ph = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cur_ph = bus_if.phase_out;
         if (cur_ph !== '0 && prev_ph === '0) begin
            if (first_pulse) check("restart_first", 32'(cur_ph), 32'h1);
            else check("restart_alt", 32'(cur_ph), (last_ph == 4'b0001) ? 32'h2 : 32'h1);
            first_pulse = 1'b0;
            last_ph = cur_ph;
         end
         prev_ph = cur_ph;
      end
      check("restart_saw_pulse", 32'(first_pulse), 32'd0);

      // Config change mid-DRIVE
      bus_if.en = 1'b0;
      wait_idle("cfg_stop");
      bus_if.mode = 1'b0; bus_if.div = 8'd3; bus_if.dead = 4'd1; bus_if.en = 1'b1;
      wait_nonzero("cfg_first_pulse", 4'b0001);
      bus_if.div = 8'd7;
      cnt = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus_if.phase_out === 4'b0001) cnt++;
         else break;
      end
      check("cfg_old_len", 32'(cnt), 32'd4);
      wait_nonzero("cfg_second_pulse", 4'b0010);
      cnt = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus_if.phase_out === 4'b0010) cnt++;
         else break;
      end
      check("cfg_new_len", 32'(cnt), 32'd8);

      // Asynchronous reset mid-DRIVE
      bus_if.en = 1'b0;
      wait_idle("rst_prep_stop");
      bus_if.mode = 1'b1; bus_if.div = 8'd3; bus_if.dead = 4'd1; bus_if.en = 1'b1;
      wait_phase(4'b0100, "rst_reach_phase2");
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_phase", 32'(bus_if.phase_out), 32'd0);
      check("rst_async_busy", 32'(bus_if.busy), 32'd0);
      check("rst_async_regulating", 32'(bus_if.regulating), 32'd0);
      bus_if.en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_after_phase", 32'(bus_if.phase_out), 32'd0);
      check("rst_after_busy", 32'(bus_if.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/dickson_phase_gen.md
# dickson_phase_gen

Parametrised non-overlapping multi-phase clock generator that drives the flying-capacitor pump clocks of the Dickson charge pump analog macro on the `ua` pins. It generalises the fixed two-phase pump drive to N phases. Phase width and dead time are programmable. It also supports pulse-skipping regulation from an external comparator. The block sits between the tile's digital config inputs (`ui_in`/`uio_in`) and the pump clock nets.

## Interface

Parameters:
- `NUM_PHASES`, 4: number of phase outputs; legal range 2..8.
- `DIV_WIDTH`, 8: width of the phase-width config.
- `DEAD_WIDTH`, 4: width of the dead-time config.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  run request.
- `mode`  in  1  0 = two-phase (phases 0,1 only); 1 = `NUM_PHASES`-phase rotation.
- `div`  in  `DIV_WIDTH`  DRIVE length minus 1, in clk cycles.
- `dead`  in  `DEAD_WIDTH`  DEAD length minus 1, in clk cycles.
- `fb_above`  in  1  asynchronous comparator output; 1 = pump output above target.
- `phase_out`  out  `NUM_PHASES`  pump clock phases; registered; at most one bit high.
- `busy`  out  1  registered; high whenever state is not IDLE.
- `regulating`  out  1  registered; high while drive is withheld by feedback.

## Operation

**Feedback synchroniser**
- `fb_above` passes through a 2-flop synchroniser to give `fb_s`. Both flops reset to 0.

**FSM states**
- IDLE:
  - `phase_out`=0. `idx`=0.
  - On `en`=1, `mode` is latched into `mode_q` and the state moves to DEAD.
- DEAD:
  - `phase_out`=0. The counter is loaded with `dead` on entry and the state lasts `dead`+1 cycles.
  - The last cycle is evaluated in this priority order:
    1. `en`=0 → IDLE.
    2. `fb_s`=1 → HOLD.
    3. Otherwise → DRIVE.
- HOLD:
  - `phase_out`=0, `regulating`=1.
  - Each cycle is evaluated in this priority order:
    1. `en`=0 → IDLE.
    2. `fb_s`=0 → DRIVE.
    3. Otherwise stay in HOLD.
  - No minimum dwell.
- DRIVE:
  - `phase_out` = one-hot(`idx`). The counter is loaded with `div` on entry and the state lasts `div`+1 cycles.
  - On exit, `idx` advances: `idx` = (`idx`+1) mod P, where P = `mode_q` ? `NUM_PHASES` : 2. The next state is DEAD.
  - If `en`=0 in any DRIVE cycle, DRIVE ends at the next edge and the state moves to DEAD (a full dead time). `idx` still advances.

**Config and dead-time rules**
- `div` and `dead` are sampled only at counter load, so changes take effect at the next DRIVE/DEAD entry.
- `mode` changes are ignored until the next IDLE→DEAD transition.
- DEAD is never skipped. `dead`=0 gives 1 cycle, which guarantees break-before-make between any two phases.
- Counters are `DIV_WIDTH`/`DEAD_WIDTH` down-counters with no wrap. Maximum values give 2^W cycles.

**Reset**
- `rst`=1 immediately forces state IDLE, `idx`=0, `mode_q`=0, both counters 0, synchroniser flops 0, `phase_out`=0, `busy`=0, `regulating`=0.
- Reset asserted mid-DRIVE clears `phase_out` without waiting for a clock edge.

## Timing

- All outputs are registered and change only on `clk` rising edges, except on `rst` assertion.
- Start latency: `en` is sampled high at edge E0.
  - `busy`=1 from E0.
  - DEAD occupies `dead`+1 cycles.
  - `phase_out[0]` rises at edge E0+`dead`+1.
- Unregulated period: P·(`div`+`dead`+2) cycles.
  - Example: mode 0, `div`=3, `dead`=1 gives a 12-cycle period.
- Feedback latency: a `fb_above` change is visible in `fb_s` 2 edges later. It is acted on at the next DEAD-end or HOLD evaluation.
- Simultaneous events:
  - `en`=0 together with `fb_s`=1 at DEAD end → IDLE. `en` wins.
  - `en`=0 on the final DRIVE cycle behaves the same as normal exit.
- Stop: IDLE and `busy`=0 are reached at the edge after the DEAD or HOLD cycle that sees `en`=0.

## Test plan

- Reset: assert `rst` mid-DRIVE with `phase_out`=0100 → `phase_out`=0000, `busy`=0, `regulating`=0 before the next clock edge. Outputs remain 0 after release while `en`=0.
- Two-phase: `mode`=0, `div`=3, `dead`=1, `fb_above`=0, `en`=1 → `phase_out` repeats 00×2, 01×4, 00×2, 10×4. Never more than one bit high; bits 2..3 always 0.
- Four-phase minimum timing: `NUM_PHASES`=4, `mode`=1, `div`=0, `dead`=0 → 0000, 0001, 0000, 0010, 0000, 0100, 0000, 1000, then repeats; every entry lasts 1 cycle.
- Regulation: mode 1, `div`=2, `dead`=1, run to phase 1. Set `fb_above`=1 before phase 1 ends → after DEAD, `phase_out` stays 0 and `regulating`=1. Clear `fb_above` → `phase_out`=0100 (phase 2) 3 edges later and `regulating`=0.
- Stop and restart: drop `en` during the second cycle of phase 2 with `div`=5, `dead`=2 → `phase_out`=0 at the next edge; 3 dead cycles follow, then `busy`=0. Re-raise `en` with `mode`=0 → phase 0 first, then alternates 01/10 only.
- Config change: change `div` from 3 to 7 mid-DRIVE → the current pulse stays 4 cycles and the next pulse is 8 cycles.
